// File: rtl/io_input_responder.sv
// io_input_responder: answers the CPU input handshake. Waits for a debounced
// press and release of the confirm key, then returns the board switches as a
// 32-bit word. The word is captured at the press and done is raised after the
// release.
// Optional build macro INPUT_SIGN_EXTEND_EN: sign-extend the switch word
// instead of zero-extending it.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | no transaction; waits for request
// WAIT_PRESS   | request seen; waits for a fresh debounced key press
// WAIT_RELEASE | switches captured; waits for the debounced key release
// DONE         | done asserted; waits for request to drop
module io_input_responder #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SW_WIDTH        = 18
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                request,
   input  logic [SW_WIDTH-1:0] sw,
   input  logic                key_confirm,
   output logic [31:0]         data_out,
   output logic                done,
   output logic                busy
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      WAIT_RELEASE = 2'd2,
      DONE         = 2'd3
   } stateT;

   stateT               state;
   stateT               nextState;
   logic                captureEn;
   logic [1:0]          keySync;
   logic [SW_WIDTH-1:0] swSync1;
   logic [SW_WIDTH-1:0] swSync2;
   logic                keyStable;
   logic [CNT_W-1:0]    debCnt;
   logic                keyDiffers;
   logic                keyFlip;
   logic                pressEvent;
   logic                releaseEvent;
   logic [31:0]         swExtended;
   logic                doneReg;

   // Two-flop synchronizers; the key idles released (1), switches idle low.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         keySync <= 2'b11;
         swSync1 <= '0;
         swSync2 <= '0;
      end else begin
         keySync <= {keySync[0], key_confirm};
         swSync1 <= sw;
         swSync2 <= swSync1;
      end
   end

   // The flip is decided in the cycle before the stable level changes, so the
   // press/release pulses line up with the edge that updates keyStable.
   assign keyDiffers   = (keySync[1] != keyStable);
   assign keyFlip      = keyDiffers && (debCnt == CNT_LAST);
   assign pressEvent   = keyFlip && !keySync[1];
   assign releaseEvent = keyFlip &&  keySync[1];

   // Debounce: count consecutive cycles the synced key differs from the stable level.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         keyStable <= 1'b1;
         debCnt    <= '0;
      end else if (!keyDiffers) begin
         debCnt    <= '0;
      end else if (keyFlip) begin
         keyStable <= keySync[1];
         debCnt    <= '0;
      end else begin
         debCnt    <= debCnt + 1'b1;
      end
   end

`ifdef INPUT_SIGN_EXTEND_EN
   assign swExtended = {{(32-SW_WIDTH){swSync2[SW_WIDTH-1]}}, swSync2};
`else
   assign swExtended = {{(32-SW_WIDTH){1'b0}}, swSync2};
`endif

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic; a falling request always wins over a key event.
   always_comb begin
      nextState = state;
      captureEn = 1'b0;
      case (state)
         IDLE: begin
            if (request) nextState = WAIT_PRESS;
         end
         WAIT_PRESS: begin
            if (!request) begin
               nextState = IDLE;
            end else if (pressEvent) begin
               nextState = WAIT_RELEASE;
               captureEn = 1'b1;
            end
         end
         WAIT_RELEASE: begin
            if (!request) begin
               nextState = IDLE;
            end else if (releaseEvent) begin
               nextState = DONE;
            end
         end
         DONE: begin
            if (!request) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Captured word and done flag; done rises the cycle after DONE is entered
   // and falls on the same edge that leaves DONE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_out <= '0;
         doneReg  <= 1'b0;
      end else begin
         if (captureEn) data_out <= swExtended;
         doneReg <= (state == DONE) && request;
      end
   end

   assign done = doneReg;
   assign busy = (state == WAIT_PRESS) || (state == WAIT_RELEASE);

endmodule

// File: tb/tb_io_input_responder.sv
// Bench for io_input_responder with DEBOUNCE_CYCLES=4, SW_WIDTH=18.
// Expected timing comes from the debounce rule: a key change reaches the FSM
// 2 + DEBOUNCE_CYCLES edges after it is driven; done follows one edge later.
module tb_io_input_responder;

   localparam int DEB  = 4;
   localparam int SWW  = 18;
   localparam int LAT  = 2 + DEB;

   logic            clock = 1'b0;
   logic            reset;
   logic            request;
   logic [SWW-1:0]  sw;
   logic            key_confirm;
   logic [31:0]     data_out;
   logic            done;
   logic            busy;

   int checks = 0;
   int errors = 0;
   logic [31:0] expData;

   io_input_responder #(.DEBOUNCE_CYCLES(DEB), .SW_WIDTH(SWW)) dut (
      .clock(clock), .reset(reset), .request(request), .sw(sw),
      .key_confirm(key_confirm), .data_out(data_out), .done(done), .busy(busy)
   );

   always #5 clock = ~clock;

   // Advance n rising edges, landing 1 ns after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Reference extension of a switch word into the 32-bit result.
   function automatic logic [31:0] extendSw(input logic [SWW-1:0] v);
      logic [31:0] r;
      r = 32'(v);
`ifdef INPUT_SIGN_EXTEND_EN
      if (v[SWW-1]) r = r | 32'hFFFC0000;
`endif
      return r;
   endfunction

   task automatic test_reset();
      reset = 1'b0; request = 1'b0; key_confirm = 1'b1; sw = 18'h3FFFF;
      step(3);
      checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: data_out=%h expected 00000000", data_out); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: done=%b expected 0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b expected 0", busy); end
      reset = 1'b1;
      sw = '0;
      step(4);
      expData = 32'h0;
   endtask

   task automatic test_basic();
      for (int i = 0; i < 4; i++) begin
         logic [SWW-1:0] v;
         int hold;
         v    = (i == 0) ? 18'h2A5F3 : SWW'($urandom);
         hold = $urandom_range(8, 14);
         sw = v;
         step($urandom_range(3, 6));
         request = 1'b1;
         step(1);
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise[%0d]: busy=%b expected 1", i, busy); end
         key_confirm = 1'b0;
         step(LAT - 1);
         checks++; if (data_out !== expData) begin errors++; $display("FAIL basic_early_capture[%0d]: data_out=%h expected %h", i, data_out, expData); end
         step(1);
         expData = extendSw(v);
         checks++; if (data_out !== expData) begin errors++; $display("FAIL basic_capture[%0d]: data_out=%h expected %h", i, data_out, expData); end
         step(hold - LAT);
         key_confirm = 1'b1;
         step(LAT);
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early[%0d]: done=%b expected 0", i, done); end
         step(1);
         checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done[%0d]: done=%b expected 1", i, done); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done[%0d]: busy=%b expected 0", i, busy); end
         step(2);
         request = 1'b0;
         step(1);
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_fall[%0d]: done=%b expected 0", i, done); end
         checks++; if (data_out !== expData) begin errors++; $display("FAIL basic_hold[%0d]: data_out=%h expected %h", i, data_out, expData); end
      end
   endtask

   task automatic test_bounce();
      int half;
      sw = SWW'($urandom);
      request = 1'b1;
      step(3);
      // glitches shorter than DEB cycles must never flip the stable level
      for (int k = 0; k < 6; k++) begin
         half = $urandom_range(1, DEB - 1);
         key_confirm = 1'b0; step(half);
         key_confirm = 1'b1; step(half);
      end
      step(10);
      checks++; if (data_out !== expData) begin errors++; $display("FAIL bounce_no_capture: data_out=%h expected %h", data_out, expData); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bounce_still_waiting: busy=%b expected 1", busy); end
      request = 1'b0;
      step(1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bounce_abort_busy: busy=%b expected 0", busy); end
   endtask

   task automatic test_held_key();
      logic [SWW-1:0] v;
      key_confirm = 1'b0;
      step(10);
      request = 1'b1;
      step(10);
      checks++; if (data_out !== expData) begin errors++; $display("FAIL held_no_capture: data_out=%h expected %h", data_out, expData); end
      v = SWW'($urandom);
      sw = v;
      key_confirm = 1'b1;
      step(10);
      checks++; if (data_out !== expData) begin errors++; $display("FAIL held_release_no_capture: data_out=%h expected %h", data_out, expData); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_busy: busy=%b expected 1", busy); end
      key_confirm = 1'b0;
      step(LAT);
      expData = extendSw(v);
      checks++; if (data_out !== expData) begin errors++; $display("FAIL held_capture: data_out=%h expected %h", data_out, expData); end
      step(3);
      key_confirm = 1'b1;
      step(LAT + 1);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL held_done: done=%b expected 1", done); end
      request = 1'b0;
      step(2);
   endtask

   task automatic test_abort();
      int doneSeen = 0;
      sw = 18'h00010;
      step(4);
      request = 1'b1;
      step(1);
      key_confirm = 1'b0;
      step(LAT);
      expData = 32'h00000010;
      checks++; if (data_out !== expData) begin errors++; $display("FAIL abort_capture: data_out=%h expected %h", data_out, expData); end
      step(3);
      request = 1'b0;
      step(1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: busy=%b expected 0", busy); end
      key_confirm = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step(1);
         if (done !== 1'b0) doneSeen++;
      end
      checks++; if (doneSeen != 0) begin errors++; $display("FAIL abort_done_seen: done high %0d cycles expected 0", doneSeen); end
      checks++; if (data_out !== expData) begin errors++; $display("FAIL abort_retain: data_out=%h expected %h", data_out, expData); end
   endtask

   task automatic test_simultaneous();
      sw = SWW'($urandom) | 18'h00100;
      step(4);
      request = 1'b1;
      step(1);
      key_confirm = 1'b0;
      step(LAT - 1);
      request = 1'b0;
      step(1);
      checks++; if (data_out !== expData) begin errors++; $display("FAIL simul_press_abort: data_out=%h expected %h", data_out, expData); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_busy: busy=%b expected 0", busy); end
      key_confirm = 1'b1;
      step(10);
   endtask

   task automatic test_sign_extend();
      logic [31:0] want;
`ifdef INPUT_SIGN_EXTEND_EN
      want = 32'hFFFE0001;
`else
      want = 32'h00020001;
`endif
      sw = 18'h20001;
      step(4);
      request = 1'b1;
      step(1);
      key_confirm = 1'b0;
      step(LAT + 2);
      checks++; if (data_out !== want) begin errors++; $display("FAIL sign_extend: data_out=%h expected %h", data_out, want); end
      expData = want;
      key_confirm = 1'b1;
      step(LAT + 1);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL sign_done: done=%b expected 1", done); end
   endtask

   task automatic test_async_reset();
      // entered with the previous transaction sitting in DONE
      #3;
      reset = 1'b0;
      #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL async_done: done=%b expected 0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: busy=%b expected 0", busy); end
      checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL async_data: data_out=%h expected 00000000", data_out); end
      request = 1'b0;
      step(2);
      reset = 1'b1;
      step(2);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_idle: busy=%b expected 0", busy); end
      expData = 32'h0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bounce();
      test_held_key();
      test_abort();
      test_simultaneous();
      test_sign_extend();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
